decode_stage: RTL
=================

# decode_stage

Parametrised successor of the MIPS D stage: owns the IF/ID pipeline register (valid, stall, flush, kill), N-source operand forwarding, branch compare, next-PC generation (branch/jump/jr/eret) and branch-delay-slot tracking for precise exceptions. Sits between fetch and the ID/EX register. The register file and hazard unit are external and remain the authority for stall and forwarding select. Optional non-delay-slot mode squashes the fall-through fetch on every redirect.

## Interface
Parameters:
- XLEN, 32, datapath width
- NFWD, 2, number of forwarding sources (excl. register file)
- DELAY_SLOT, 1, 1 = MIPS delay slot; 0 = redirect kills the fetched instruction
- SELW, $clog2(NFWD+1), forward-select width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  fetched instruction
- if_pc  in  XLEN  PC of fetched instruction
- stall  in  1  hazard unit: hold IF/ID
- flush  in  1  exception/interrupt: empty IF/ID
- rf_rd1, rf_rd2  in  XLEN  register file reads for rs/rt of id_instr
- fwd_data  in  NFWD*XLEN  packed forwarding values, source k at [k*XLEN +: XLEN]
- fwd_sel_rs, fwd_sel_rt  in  SELW  0 = RF, k = fwd source k-1
- epc  in  XLEN  CP0 EPC
- id_instr  out  32  instruction to E (0 when invalid or squashed bgezal)
- id_pc  out  XLEN  PC of D instruction
- id_valid  out  1  D holds a live instruction
- id_bd  out  1  D instruction is in a branch delay slot
- rs_val, rt_val  out  XLEN  forwarded operands
- ext_imm  out  XLEN  sign/zero/lui-extended immediate
- npc  out  XLEN  redirect target
- pc_sel  out  1  fetch must load npc
- exl_clr  out  1  eret in D

## Operation
- IF/ID register update priority each edge: flush > stall > kill > load. Flush: id_valid=0, id_instr=0, id_bd=0. Stall: all held. Kill (DELAY_SLOT=0 with pc_sel, or eret with pc_sel in either mode): load as invalid nop. Load: capture if_instr/if_pc, id_valid=if_valid.
- id_bd register: on load, set to 1 iff the current D instruction is a valid branch/jump (taken or not); cleared on flush; held on stall.
- Forwarding: rs_val/rt_val from N-way mux; select > NFWD yields RF value.
- Compare: beq, bne, blez, bgtz, bltz, bgez, bltzal, bgezal on forwarded values, signed XLEN.
- npc: branch = id_pc+4+(sext(imm)<<2); j/jal = {id_pc[XLEN-1:28], idx, 2'b00}; jr/jalr = rs_val; eret = epc.
- pc_sel = id_valid & ~stall & (taken branch | jump | eret). Forced 0 while stalled.
- bgezal/bltzal not taken: id_instr=0 (no link write); id_valid unchanged.
- exl_clr = id_valid & (instr == 32'h42000018).

## Timing
- Reset (asserted, async): id_instr=0, id_pc=0, id_valid=0, id_bd=0; combinational outputs then settle to pc_sel=0, exl_clr=0.
- IF/ID latency 1 cycle; all decode outputs combinational from the register and forwarded inputs within the same cycle.
- Stall held N cycles: outputs stable, pc_sel=0 throughout; redirect issues in the first unstalled cycle.
- flush and stall same cycle: flush wins. flush with pc_sel: flush wins; fetch redirect is the exception vector (owned externally).
- Reset deassertion mid-fetch: first edge after release loads normally.

## Structure
- Package cpu_defs_pkg: opcode/funct/rt constants, ERET encoding, npc kind enum, ext op enum.
- Sub-module fwd_mux (XLEN, NFWD) instantiated twice; compare, extend and npc logic inline.

## Test plan
- Reset low mid-run -> id_valid=0, id_instr=0 immediately; pc_sel=0.
- beq $1,$2 with fwd_sel_rs=1, fwd source 0=5, rt RF=5, id_pc=0x3000, imm=4 -> pc_sel=1, npc=0x3014; next instruction loaded has id_bd=1 (DELAY_SLOT=1).
- Same with DELAY_SLOT=0 -> following D is invalid nop, id_bd=0.
- Stall 3 cycles on jr with rs forwarded=0x3100 -> pc_sel=0 for 3 cycles, then pc_sel=1, npc=0x3100.
- eret with epc=0x3040 -> exl_clr=1, npc=0x3040, next D invalid.
- bgezal with rs=-1 -> id_instr=0, pc_sel=0; flush+stall together -> id_valid=0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// MIPS decode constants, redirect-kind and immediate-extension enums.
// Pure definitions: no latency, no flow control.
package cpu_defs_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

  typedef enum logic [2:0] {NPC_NONE, NPC_BR, NPC_J, NPC_JR, NPC_ERET} npc_kind_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_op_e;

  function automatic ext_op_e ext_op_of(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: return EXT_ZERO;
      OP_LUI:                   return EXT_LUI;
      default:                  return EXT_SIGN;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/hazard/CP0 <-> decode bundle; master drives the decode inputs.
// No handshake: stall/flush from the hazard unit are the only backpressure.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int SELW = $clog2(NFWD + 1)
);
  logic                 if_valid;
  logic [31:0]          if_instr;
  logic [XLEN-1:0]      if_pc;
  logic                 stall;
  logic                 flush;
  logic [XLEN-1:0]      rf_rd1;
  logic [XLEN-1:0]      rf_rd2;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [SELW-1:0]      fwd_sel_rs;
  logic [SELW-1:0]      fwd_sel_rt;
  logic [XLEN-1:0]      epc;

  logic [31:0]          id_instr;
  logic [XLEN-1:0]      id_pc;
  logic                 id_valid;
  logic                 id_bd;
  logic [XLEN-1:0]      rs_val;
  logic [XLEN-1:0]      rt_val;
  logic [XLEN-1:0]      ext_imm;
  logic [XLEN-1:0]      npc;
  logic                 pc_sel;
  logic                 exl_clr;

  modport master (
    output if_valid, if_instr, if_pc, stall, flush, rf_rd1, rf_rd2,
           fwd_data, fwd_sel_rs, fwd_sel_rt, epc,
    input  id_instr, id_pc, id_valid, id_bd, rs_val, rt_val, ext_imm,
           npc, pc_sel, exl_clr
  );

  modport slave (
    input  if_valid, if_instr, if_pc, stall, flush, rf_rd1, rf_rd2,
           fwd_data, fwd_sel_rs, fwd_sel_rt, epc,
    output id_instr, id_pc, id_valid, id_bd, rs_val, rt_val, ext_imm,
           npc, pc_sel, exl_clr
  );
endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding mux: sel 0 or out-of-range picks the RF value, k picks source k-1.
// Combinational, no backpressure.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic [SELW-1:0]      sel,
  input  logic [XLEN-1:0]      rf,
  input  logic [NFWD*XLEN-1:0] fwd,
  output logic [XLEN-1:0]      dout
);

  always_comb begin
    dout = rf;
    for (int k = 1; k <= NFWD; k++) begin
      if (sel == SELW'(k)) dout = fwd[(k-1)*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS D stage: IF/ID register, forwarding, branch compare, next-PC and delay-slot tracking.
// IF/ID latency 1; decode outputs combinational; held by stall, emptied by flush.
module decode_stage
  import cpu_defs_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NFWD       = 2,
  parameter int DELAY_SLOT = 1,
  parameter int SELW       = $clog2(NFWD + 1)
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  localparam logic DS = (DELAY_SLOT != 0);

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            bd_q;

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [4:0]      rt;
  logic [15:0]     imm;
  logic [25:0]     idx;
  logic            rs_neg;
  logic            rs_zero;
  logic            rs_eq_rt;
  npc_kind_e       kind;
  logic            taken;
  logic            is_bj;
  logic            link_squash;
  logic            pc_sel;
  logic            kill;

  assign op    = instr_q[31:26];
  assign idx   = instr_q[25:0];
  assign rt    = instr_q[20:16];
  assign imm   = instr_q[15:0];
  assign funct = instr_q[5:0];

  fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_fwd_rs (
    .sel  (bus.fwd_sel_rs),
    .rf   (bus.rf_rd1),
    .fwd  (bus.fwd_data),
    .dout (rs_val)
  );

  fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_fwd_rt (
    .sel  (bus.fwd_sel_rt),
    .rf   (bus.rf_rd2),
    .fwd  (bus.fwd_data),
    .dout (rt_val)
  );

  // Signed compares reduce to sign bit and zero test of rs.
  assign rs_neg   = rs_val[XLEN-1];
  assign rs_zero  = (rs_val == '0);
  assign rs_eq_rt = (rs_val == rt_val);

  always_comb begin
    kind        = NPC_NONE;
    taken       = 1'b0;
    is_bj       = 1'b0;
    link_squash = 1'b0;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          kind  = NPC_JR;
          taken = 1'b1;
          is_bj = 1'b1;
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: begin
            kind  = NPC_BR;
            is_bj = 1'b1;
            taken = rs_neg;
          end
          RT_BGEZ, RT_BGEZAL: begin
            kind  = NPC_BR;
            is_bj = 1'b1;
            taken = ~rs_neg;
          end
          default: ;
        endcase
        link_squash = (rt == RT_BLTZAL || rt == RT_BGEZAL) && !taken;
      end
      OP_J, OP_JAL: begin
        kind  = NPC_J;
        taken = 1'b1;
        is_bj = 1'b1;
      end
      OP_BEQ: begin kind = NPC_BR; is_bj = 1'b1; taken = rs_eq_rt;            end
      OP_BNE: begin kind = NPC_BR; is_bj = 1'b1; taken = ~rs_eq_rt;           end
      OP_BLEZ: begin kind = NPC_BR; is_bj = 1'b1; taken = rs_neg | rs_zero;   end
      OP_BGTZ: begin kind = NPC_BR; is_bj = 1'b1; taken = ~(rs_neg | rs_zero); end
      default: begin
        if (instr_q == ERET_INSTR) begin
          kind  = NPC_ERET;
          taken = 1'b1;
        end
      end
    endcase
  end

  assign pc4    = pc_q + XLEN'(4);
  assign br_off = XLEN'($signed({imm, 2'b00}));

  always_comb begin
    case (kind)
      NPC_BR:   bus.npc = pc4 + br_off;
      NPC_J:    bus.npc = {pc_q[XLEN-1:28], idx, 2'b00};
      NPC_JR:   bus.npc = rs_val;
      NPC_ERET: bus.npc = bus.epc;
      default:  bus.npc = pc4;
    endcase
  end

  always_comb begin
    case (ext_op_of(op))
      EXT_ZERO: bus.ext_imm = XLEN'(imm);
      EXT_LUI:  bus.ext_imm = XLEN'($signed({imm, 16'h0000}));
      default:  bus.ext_imm = XLEN'($signed(imm));
    endcase
  end

  assign pc_sel = valid_q & ~bus.stall & taken;
  // eret never has a delay slot, so its fall-through is dropped in both modes.
  assign kill   = pc_sel & (~DS | (kind == NPC_ERET));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else if (bus.flush) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= bus.if_pc;
      if (kill) begin
        instr_q <= '0;
        valid_q <= 1'b0;
        bd_q    <= 1'b0;
      end else begin
        instr_q <= bus.if_instr;
        valid_q <= bus.if_valid;
        bd_q    <= DS & valid_q & is_bj;
      end
    end
  end

  assign bus.id_instr = (valid_q && !link_squash) ? instr_q : 32'h0;
  assign bus.id_pc    = pc_q;
  assign bus.id_valid = valid_q;
  assign bus.id_bd    = bd_q;
  assign bus.rs_val   = rs_val;
  assign bus.rt_val   = rt_val;
  assign bus.pc_sel   = pc_sel;
  assign bus.exl_clr  = valid_q & (instr_q == ERET_INSTR);

endmodule
